spi_sprite_master_tx: RTL and testbench
=======================================

Name: spi_sprite_master_tx

Overview:
- FPGA-side SPI master that streams one complete sprite frame to a sprite SPI slave: command word, colour header, then packed pixel words.
- Mode 0 (SCK idle low), MOSI only, MSB first, 32-bit words.
- Receiving slave samples on SCK rising edge and processes on falling edge.
- Pixel words are fetched from a synchronous word-wide sprite ROM/RAM. Used for board-to-board sprite transfer and for loopback self-test of the slave.

Parameters:
NUMPIXELS, 1024, pixels per sprite; NUMPIXELS*BITSPERPIXEL must be divisible by 32
BITSPERPIXEL, 4, bits per pixel index
NUMCOLORSINHEADER, 4, colour entries sent in the header
CLKDIV, 4, clk cycles per SCK half-period (>=1)
CMDWORD, 32'h0000_0001, value sent as the command word

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to send one frame
header_colors  input  NUMCOLORSINHEADER*24  colour i at [24*i+23:24*i], {r,g,b}; sampled word by word during transmission
mem_rd  output  1  read strobe to pixel memory
mem_addr  output  $clog2(NUMPIXELS*BITSPERPIXEL/32)  pixel word address
mem_rdata  input  32  pixel word, valid the cycle after mem_rd
sck  output  1  SPI clock
mosi  output  1  SPI data
busy  output  1  high while a frame is in progress
done  output  1  one-cycle pulse when the frame is complete

Behaviour:
- Frame layout:
  - Word 0 = CMDWORD.
  - Words 1..NUMCOLORSINHEADER = {8'h00, header_colors[color i]}, i = 0 upward.
  - Then NPW = NUMPIXELS*BITSPERPIXEL/32 pixel words, read from mem_addr 0..NPW-1. Default total is 133 words.
  - Within a pixel word, the first pixel is in the most significant nibble.
- States: IDLE, FETCH, LOAD, SHIFT, FINISH.
- IDLE:
  - sck=0, mosi=0, busy=0.
  - start=1 -> FETCH with word index 0; busy=1 from the next cycle.
- FETCH (1 cycle):
  - For a pixel word, drive mem_rd=1 and mem_addr = word index - 1 - NUMCOLORSINHEADER.
  - mem_rd=0 in all other states and for command/header words.
- LOAD (1 cycle):
  - Shift register <= CMDWORD, header word, or mem_rdata as appropriate; bit counter = 0.
  - mosi takes shreg[31] from the next cycle.
- SHIFT:
  - Low phase: sck=0 for CLKDIV cycles, then sck rises.
  - High phase: sck=1 for CLKDIV cycles, then sck falls. On the same cycle the shift register shifts left by one and the bit counter increments.
  - mosi = shreg[31] at all times in SHIFT, so data is stable a full half-period before each rising edge.
  - After the 32nd falling edge: if more words remain -> FETCH with word index+1; else -> FINISH.
- Per-word cost: exactly 32 rising and 32 falling edges, plus a 2-cycle gap with sck=0 (FETCH, LOAD) between words. The slave must see the final falling edge of each word.
- FINISH (1 cycle): done=1, busy=0, mosi=0 -> IDLE.
- Reset values: sck=0, mosi=0, busy=0, done=0, mem_rd=0, mem_addr=0, state IDLE, all counters 0.
- start while busy: ignored; no restart, no queueing.
- start asserted in the same cycle as done: ignored. A new frame requires start while in IDLE.
- Reset mid-frame: immediate return to IDLE with sck low. A partial frame is abandoned; the slave must be resynchronised externally.
- header_colors change mid-frame: each word uses the value present in its LOAD cycle.
- Counter widths: word index sized for 1+NUMCOLORSINHEADER+NPW; bit counter 5 bits (0..31, terminal 31 after the 32nd shift); divider $clog2(CLKDIV)+1 bits.

Optional Feature:
SPI_TX_CS_EN:
- Defined: adds output cs_n (1 bit, reset/idle 1).
  - cs_n falls on the cycle leaving IDLE and is held low CLKDIV extra cycles before the first low phase begins.
  - cs_n stays low across all inter-word gaps.
  - After the final falling edge, cs_n is held low CLKDIV cycles, then rises in the FINISH cycle.
- Undefined: no cs_n port; timing exactly as in Behaviour.

Test Plan:
- Reset then idle 20 cycles -> sck=0, mosi=0, busy=0, done=0, mem_rd=0 throughout.
- CLKDIV=4, start pulse -> the bench's model slave captures on sck rise:
  - word 0 = 32'h0000_0001;
  - header words {8'h00, colours} for colours FF0000, 00FF00, 0000FF, 123456;
  - 128 pixel words equal to the ROM contents (ROM word k = 32'h0123_4567 + k);
  - exactly 4256 rising edges; done pulses once.
- Timing check, CLKDIV=4: each sck high and low phase lasts 4 cycles; mosi never changes within 1 cycle before a rising edge or while sck=1.
- mem_rd/mem_addr check: mem_rd pulses exactly 128 times with addresses 0..127 in order; each mem_rdata is used the following cycle.
- start re-pulsed at word 50 -> no effect, frame completes normally. reset at word 70 -> sck=0 and busy=0 asynchronously; a subsequent start sends a complete fresh frame beginning with CMDWORD.
- With SPI_TX_CS_EN: cs_n=1 at reset; low ≥4 cycles before the first sck rise; continuously low through all inter-word gaps; high ≥4 cycles after the last sck fall, coincident with done.

Source files
------------

// File: rtl/spi_sprite_master_tx.sv
// spi_sprite_master_tx
// SPI mode 0 master (MOSI only, MSB first, 32-bit words) that streams one
// sprite frame: command word, colour header words, then packed pixel words
// fetched from a synchronous word-wide memory.
// Optional feature macro: SPI_TX_CS_EN adds an active-low chip select cs_n
// with CLKDIV-cycle lead and tail guard times around the frame.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for start, SPI lines quiet
// S_LEAD   | cs_n low, guard time before first word (SPI_TX_CS_EN only)
// S_FETCH  | memory read strobe for pixel words, sck low
// S_LOAD   | shift register loaded with command/header/pixel word
// S_SHIFT  | 32 sck periods of CLKDIV low + CLKDIV high cycles
// S_TAIL   | cs_n still low, guard time after last fall (SPI_TX_CS_EN only)
// S_FINISH | done pulse, busy dropped

module spi_sprite_master_tx #(
  parameter int          NUMPIXELS         = 1024,
  parameter int          BITSPERPIXEL      = 4,
  parameter int          NUMCOLORSINHEADER = 4,
  parameter int          CLKDIV            = 4,
  parameter logic [31:0] CMDWORD           = 32'h0000_0001,
  localparam int         NPW               = NUMPIXELS * BITSPERPIXEL / 32,
  localparam int         AW                = (NPW > 1) ? $clog2(NPW) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [NUMCOLORSINHEADER*24-1:0] header_colors,
  output logic                            mem_rd,
  output logic [AW-1:0]                   mem_addr,
  input  logic [31:0]                     mem_rdata,
  output logic                            sck,
  output logic                            mosi,
  output logic                            busy,
  output logic                            done
`ifdef SPI_TX_CS_EN
  ,
  output logic                            cs_n
`endif
);

  localparam int NWORDS = 1 + NUMCOLORSINHEADER + NPW;
  localparam int WIDXW  = $clog2(NWORDS + 1);
  localparam int DIVW   = $clog2(CLKDIV) + 1;

  localparam logic [DIVW-1:0]  DIV_LOAD = DIVW'(CLKDIV - 1);
  localparam logic [WIDXW-1:0] LAST_IDX = WIDXW'(NWORDS - 1);
  localparam logic [WIDXW-1:0] NC_IDX   = WIDXW'(NUMCOLORSINHEADER);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SHIFT,
    S_FINISH
`ifdef SPI_TX_CS_EN
    ,
    S_LEAD,
    S_TAIL
`endif
  } state_t;

  state_t           r_state;
  logic [WIDXW-1:0] r_word_idx;
  logic [4:0]       r_bit_cnt;
  logic [DIVW-1:0]  r_div;
  logic [31:0]      r_shreg;
  logic             r_sck;
  logic             r_mosi;
  logic             r_busy;
  logic             r_done;
  logic             r_mem_rd;
  logic [AW-1:0]    r_mem_addr;
`ifdef SPI_TX_CS_EN
  logic             r_cs_n;
`endif

  logic [31:0]      w_hdr_word;
  logic [31:0]      w_load_word;
  logic             w_next_is_pixel;
  logic [AW-1:0]    w_next_addr;

  // header word for the current word index, sampled live in LOAD
  always_comb begin
    w_hdr_word = '0;
    for (int i = 0; i < NUMCOLORSINHEADER; i++) begin
      if (r_word_idx == WIDXW'(i + 1)) begin
        w_hdr_word = {8'h00, header_colors[24*i +: 24]};
      end
    end
  end

  // pick what the shift register is loaded with, and where the next pixel read goes
  always_comb begin
    if (r_word_idx == '0) begin
      w_load_word = CMDWORD;
    end else if (r_word_idx <= NC_IDX) begin
      w_load_word = w_hdr_word;
    end else begin
      w_load_word = mem_rdata;
    end
    w_next_is_pixel = (r_word_idx >= NC_IDX);
    w_next_addr     = AW'(r_word_idx - NC_IDX);
  end

  // frame sequencer with registered SPI and memory outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_word_idx <= '0;
      r_bit_cnt  <= '0;
      r_div      <= '0;
      r_shreg    <= '0;
      r_sck      <= 1'b0;
      r_mosi     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_mem_rd   <= 1'b0;
      r_mem_addr <= '0;
`ifdef SPI_TX_CS_EN
      r_cs_n     <= 1'b1;
`endif
    end else begin
      r_done   <= 1'b0;
      r_mem_rd <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_sck  <= 1'b0;
          r_mosi <= 1'b0;
          if (start) begin
            r_busy     <= 1'b1;
            r_word_idx <= '0;
            r_bit_cnt  <= '0;
`ifdef SPI_TX_CS_EN
            r_cs_n  <= 1'b0;
            r_div   <= DIV_LOAD;
            r_state <= S_LEAD;
`else
            r_state <= S_FETCH;
`endif
          end
        end
`ifdef SPI_TX_CS_EN
        S_LEAD: begin
          if (r_div == '0) begin
            r_state <= S_FETCH;
          end else begin
            r_div <= r_div - 1'b1;
          end
        end
        S_TAIL: begin
          if (r_div == '0) begin
            r_cs_n  <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_mosi  <= 1'b0;
            r_state <= S_FINISH;
          end else begin
            r_div <= r_div - 1'b1;
          end
        end
`endif
        S_FETCH: begin
          r_state <= S_LOAD;
        end
        S_LOAD: begin
          r_shreg   <= w_load_word;
          r_mosi    <= w_load_word[31];
          r_bit_cnt <= '0;
          r_div     <= DIV_LOAD;
          r_sck     <= 1'b0;
          r_state   <= S_SHIFT;
        end
        S_SHIFT: begin
          if (r_div != '0) begin
            r_div <= r_div - 1'b1;
          end else begin
            r_div <= DIV_LOAD;
            r_sck <= ~r_sck;
            if (r_sck) begin
              // falling edge: slave has sampled this bit, present the next one
              r_shreg   <= {r_shreg[30:0], 1'b0};
              r_mosi    <= r_shreg[30];
              r_bit_cnt <= r_bit_cnt + 5'd1;
              if (r_bit_cnt == 5'd31) begin
                if (r_word_idx == LAST_IDX) begin
`ifdef SPI_TX_CS_EN
                  r_state <= S_TAIL;
`else
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_mosi  <= 1'b0;
                  r_state <= S_FINISH;
`endif
                end else begin
                  r_word_idx <= r_word_idx + 1'b1;
                  r_state    <= S_FETCH;
                  if (w_next_is_pixel) begin
                    r_mem_rd   <= 1'b1;
                    r_mem_addr <= w_next_addr;
                  end
                end
              end
            end
          end
        end
        S_FINISH: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign sck      = r_sck;
  assign mosi     = r_mosi;
  assign busy     = r_busy;
  assign done     = r_done;
  assign mem_rd   = r_mem_rd;
  assign mem_addr = r_mem_addr;
`ifdef SPI_TX_CS_EN
  assign cs_n     = r_cs_n;
`endif

endmodule

// File: tb/tb_spi_sprite_master_tx.sv
// Bench for spi_sprite_master_tx: a model slave captures words on sck rise
// and compares them with a frame built from the colour/ROM contents.
module tb_spi_sprite_master_tx;

  localparam int NP  = 1024;
  localparam int BPP = 4;
  localparam int NC  = 4;
  localparam int CD  = 4;
  localparam int NPW = NP * BPP / 32;
  localparam int NW  = 1 + NC + NPW;
  localparam int AW  = $clog2(NPW);
  localparam logic [31:0] CMD = 32'h0000_0001;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [NC*24-1:0]  header_colors;
  logic              mem_rd;
  logic [AW-1:0]     mem_addr;
  logic [31:0]       mem_rdata;
  logic              sck;
  logic              mosi;
  logic              busy;
  logic              done;
`ifdef SPI_TX_CS_EN
  logic              cs_n;
`endif

  always #5 clk = ~clk;

  spi_sprite_master_tx #(
    .NUMPIXELS(NP), .BITSPERPIXEL(BPP), .NUMCOLORSINHEADER(NC),
    .CLKDIV(CD), .CMDWORD(CMD)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .header_colors(header_colors),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .sck(sck), .mosi(mosi), .busy(busy), .done(done)
`ifdef SPI_TX_CS_EN
    , .cs_n(cs_n)
`endif
  );

  // synchronous ROM: word k = rom_base + k; garbage whenever not read
  logic [31:0] rom_base = 32'h0123_4567;
  always @(posedge clk) mem_rdata <= mem_rd ? rom_base + 32'(mem_addr) : $urandom;

  // model slave and protocol monitor, sampled on the falling clk edge
  int          cyc = 0, rises = 0, falls = 0, dones = 0, rd_cnt = 0, rd_next = 0;
  int          rd_bad = 0, hi_bad = 0, lo_bad = 0, mosi_bad = 0, done_busy_bad = 0;
  int          cap_cnt = 0, cap_bits = 0, run_len = 0, last_mchg = -100;
  bit          run_from_fall = 0;
  logic [31:0] cap_sh = '0;
  logic [31:0] cap_mem [0:1023];
  logic        p_sck = 1'b0, p_mosi = 1'b0;
`ifdef SPI_TX_CS_EN
  int          cs_bad = 0, cs_low_len = 0, since_fall = 0, frame_rises = 0;
`endif

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      cap_bits = 0; rd_next = 0; run_len = 0; run_from_fall = 0;
`ifdef SPI_TX_CS_EN
      frame_rises = 0; cs_low_len = 0;
`endif
    end else begin
      if (mosi !== p_mosi) begin
        if (p_sck && sck) mosi_bad++;
        last_mchg = cyc;
      end
`ifdef SPI_TX_CS_EN
      if (cs_n === 1'b0) cs_low_len++; else cs_low_len = 0;
      since_fall++;
      if (sck && cs_n !== 1'b0) cs_bad++;
      if (busy && !done && cs_n !== 1'b0) cs_bad++;
`endif
      if (sck && !p_sck) begin
        rises++;
        if (cyc - last_mchg <= 1) mosi_bad++;
        if (run_from_fall && run_len != CD && run_len != CD + 2) lo_bad++;
`ifdef SPI_TX_CS_EN
        if (frame_rises == 0 && cs_low_len - 1 < CD) cs_bad++;
        frame_rises++;
`endif
        cap_sh = {cap_sh[30:0], mosi};
        cap_bits++;
        if (cap_bits == 32) begin
          cap_mem[cap_cnt % 1024] = cap_sh;
          cap_cnt++;
          cap_bits = 0;
        end
        run_len = 1;
      end else if (!sck && p_sck) begin
        falls++;
        if (run_len != CD) hi_bad++;
        run_len = 1;
        run_from_fall = 1;
`ifdef SPI_TX_CS_EN
        since_fall = 0;
`endif
      end else begin
        run_len++;
      end
      if (mem_rd) begin
        rd_cnt++;
        if (mem_addr !== AW'(rd_next)) rd_bad++;
        rd_next = (rd_next + 1) % NPW;
      end
      if (done) begin
        dones++;
        if (busy) done_busy_bad++;
        run_from_fall = 0;
`ifdef SPI_TX_CS_EN
        if (cs_n !== 1'b1) cs_bad++;
        if (since_fall < CD) cs_bad++;
        frame_rises = 0;
`endif
      end
    end
    p_sck  = sck;
    p_mosi = mosi;
  end

  int          n_pass = 0, n_total = 0, n_fail = 0;
  logic [31:0] exp_w [0:NW-1];
  int          cap0, rise0, done0, rd0;
  bit          ok;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // expected frame from the frame layout rules
  task automatic build_exp();
    exp_w[0] = CMD;
    for (int i = 0; i < NC; i++) exp_w[1 + i] = {8'h00, header_colors[24*i +: 24]};
    for (int k = 0; k < NPW; k++) exp_w[1 + NC + k] = rom_base + 32'(k);
  endtask

  task automatic snap();
    cap0 = cap_cnt; rise0 = rises; done0 = dones; rd0 = rd_cnt;
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic wait_words(input int n, output bit seen);
    seen = 0;
    for (int c = 0; c < 40000 && !seen; c++) begin
      @(negedge clk);
      if (cap_cnt - cap0 >= n) seen = 1;
    end
  endtask

  task automatic wait_done(output bit seen);
    seen = 0;
    for (int c = 0; c < 40000 && !seen; c++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
    end
  endtask

  task automatic check_frame(input string nm);
    for (int i = 0; i < NW; i++)
      chk($sformatf("%s_word%0d", nm, i), cap_mem[(cap0 + i) % 1024], exp_w[i]);
    chk({nm, "_rises"}, 32'(rises - rise0), 32'(32 * NW));
    chk({nm, "_done_count"}, 32'(dones - done0), 32'd1);
    chk({nm, "_mem_reads"}, 32'(rd_cnt - rd0), 32'(NPW));
  endtask

  initial begin
    int bad;
    reset = 1'b1; start = 1'b0; header_colors = '0;
    repeat (3) @(negedge clk);
    chk("rst_sck", 32'(sck), 0);
    chk("rst_mosi", 32'(mosi), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_mem_rd", 32'(mem_rd), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
`ifdef SPI_TX_CS_EN
    chk("rst_cs_n", 32'(cs_n), 1);
`endif
    reset = 1'b0;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (sck !== 1'b0 || mosi !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || mem_rd !== 1'b0) bad++;
    end
    chk("idle_quiet", 32'(bad), 0);

    // frame 1: fixed colours and ROM, start re-pulsed mid-frame and on done
    header_colors = {24'h123456, 24'h0000FF, 24'h00FF00, 24'hFF0000};
    rom_base = 32'h0123_4567;
    build_exp();
    snap();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
    wait_words(50, ok);
    chk("f1_reach_word50", 32'(ok), 1);
    pulse_start();
    wait_done(ok);
    chk("f1_done_seen", 32'(ok), 1);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    check_frame("f1");
    chk("start_on_done_ignored", 32'(busy), 0);

    // frame 2: random contents, abandoned by reset at word 70
    for (int i = 0; i < NC; i++) header_colors[24*i +: 24] = 24'($urandom);
    rom_base = $urandom;
    snap();
    pulse_start();
    wait_words(70, ok);
    chk("f2_reach_word70", 32'(ok), 1);
    #1 reset = 1'b1;
    #1;
    chk("abort_sck", 32'(sck), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_mem_rd", 32'(mem_rd), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // frame 3: fresh complete frame after the abort
    for (int i = 0; i < NC; i++) header_colors[24*i +: 24] = 24'($urandom);
    rom_base = $urandom;
    build_exp();
    snap();
    pulse_start();
    wait_done(ok);
    chk("f3_done_seen", 32'(ok), 1);
    repeat (4) @(negedge clk);
    check_frame("f3");

    chk("sck_high_phase", 32'(hi_bad), 0);
    chk("sck_low_phase", 32'(lo_bad), 0);
    chk("mosi_stability", 32'(mosi_bad), 0);
    chk("mem_addr_order", 32'(rd_bad), 0);
    chk("busy_low_on_done", 32'(done_busy_bad), 0);
`ifdef SPI_TX_CS_EN
    chk("cs_n_framing", 32'(cs_bad), 0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
